fp_issue_ctrl: RTL
==================

Name: fp_issue_ctrl

Overview:
- Sequences the multi-cycle floating-point unit (ADDF/MULTF) in the 16-bit pipelined processor's EX stage.
- Sits between the ID/EX register outputs and the hazard unit.
- Holds PC, IF/ID and ID/EX while an FP op is in flight, bubbles EX/MEM, and strobes the FP result into EX/MEM on the last cycle.
- Also sequences the STOP drain-and-halt.

Parameters:
- ADDF_LAT, 3, total EX-occupancy cycles of ADDF (legal 2..15)
- MULTF_LAT, 5, total EX-occupancy cycles of MULTF (legal 2..15)
- DRAIN_CYC, 3, cycles after STOP seen before halt (legal 1..15)
- REG_WIDTH, 4, register index width
- CNT_W, 4, latency counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
- FloatingE_i  in  1  FP instruction present in EX
- fp_mul_i  in  1  1=MULTF, 0=ADDF; valid with FloatingE_i
- rdE_i  in  REG_WIDTH  destination register of the EX instruction
- stop_i  in  1  Stop from the ID-stage decoder
- flush_i  in  1  EX-stage flush from the branch/jump logic
- fp_start_o  out  1  one-cycle start pulse to the FP unit
- fp_op_o  out  1  latched op select (1=mul)
- fp_abort_o  out  1  one-cycle abort pulse to the FP unit
- fp_result_valid_o  out  1  EX/MEM captures the FP result this cycle
- fp_busy_o  out  1  FP op in flight
- fp_rd_o  out  REG_WIDTH  latched destination of the in-flight op (for the hazard unit)
- stall_PC_o  out  1  hold PC
- stall_IF_ID_o  out  1  hold IF/ID
- stall_ID_EX_o  out  1  hold ID/EX
- bubble_EX_MEM_o  out  1  load a bubble into EX/MEM
- halted_o  out  1  processor halted

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, cnt=0, fp_op_o=0, fp_rd_o=0.
  - All outputs are 0 in the following cycle.
  - Reset mid-operation abandons any op silently; no fp_abort_o pulse.
- States: IDLE, BUSY, WB, DRAIN, HALT. Outputs decode combinationally from state and inputs; state, cnt, fp_op_o and fp_rd_o are registered.
- IDLE, FP start:
  - Condition: FloatingE_i=1 and flush_i=0.
  - Same cycle: fp_start_o=1; all three stalls=1; bubble_EX_MEM_o=1.
  - Latch fp_op_o<=fp_mul_i and fp_rd_o<=rdE_i.
  - Let LAT = MULTF_LAT if fp_mul_i else ADDF_LAT.
  - If LAT==2, next state is WB. Otherwise next state is BUSY with cnt<=LAT-3.
- IDLE, other cases:
  - FloatingE_i=1 and flush_i=1: no start; stay IDLE.
  - FP start takes priority over stop_i in the same cycle. ID is stalled, so stop_i is re-presented later.
  - Otherwise, stop_i=1 goes to DRAIN with cnt<=DRAIN_CYC-1.
- BUSY:
  - Stalls=1, bubble=1, fp_busy_o=1.
  - cnt==0 goes to WB; otherwise cnt decrements.
  - stop_i is ignored here.
  - flush_i=1: fp_abort_o=1 this cycle, next state IDLE. Stalls stay 1 this cycle; the flush owner clears ID/EX.
- WB:
  - fp_result_valid_o=1, fp_busy_o=1, stalls=0, bubble=0.
  - Next state is always IDLE.
  - flush_i in WB suppresses fp_result_valid_o (forced 0) and raises fp_abort_o.
- Occupancy: EX occupancy of an FP op is exactly LAT cycles (start cycle + LAT-2 BUSY + 1 WB).
- Back-to-back FP: the next FP instruction enters EX in the cycle after WB and starts from IDLE. There are no idle cycles between ops.
- DRAIN:
  - stall_PC_o=1 and stall_IF_ID_o=1; older instructions drain.
  - cnt==0 goes to HALT; otherwise cnt decrements.
  - FloatingE_i and flush_i are ignored.
- HALT: stall_PC_o=stall_IF_ID_o=stall_ID_EX_o=1 and halted_o=1. Leaves HALT only via reset.
- fp_busy_o=1 in BUSY and WB only.
- fp_rd_o holds its value when not busy; the hazard unit qualifies it with fp_busy_o.
- All counter arithmetic is unsigned in CNT_W bits; the counter never wraps, since the legal parameter range guarantees this.

Test Plan:
- ADDF (LAT=3), rdE_i=4'd7, FloatingE_i high 1 cycle → fp_start_o at c0; stalls at c0–c1; fp_result_valid_o at c2 only; fp_rd_o=7 during c1–c2; back to IDLE at c3.
- MULTF immediately followed by ADDF → stalls for 4 cycles, valid at c4, second fp_start_o at c5, valid at c7; no gap cycles.
- flush_i=1 at BUSY c1 of MULTF → fp_abort_o pulse at c1, no fp_result_valid_o, IDLE at c2. Also FloatingE_i=1 with flush_i=1 in IDLE → no fp_start_o.
- stop_i=1 in IDLE (DRAIN_CYC=3) → stall_PC_o from c0; halted_o=1 from c3 onward; FloatingE_i pulses during DRAIN produce no start.
- rst=0 during BUSY → next cycle all outputs 0, state IDLE, no abort pulse. Afterwards a new ADDF runs normally.
- FloatingE_i=1 and stop_i=1 in the same IDLE cycle → FP starts. After WB, held stop_i enters DRAIN.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: sequences the multi-cycle FP unit (ADDF/MULTF) in the EX stage
// and the STOP drain-and-halt. It drives the pipeline stall/bubble controls
// and the FP unit start/abort strobes.
module fp_issue_ctrl #(
    parameter int ADDF_LAT  = 3,
    parameter int MULTF_LAT = 5,
    parameter int DRAIN_CYC = 3,
    parameter int REG_WIDTH = 4,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 FloatingE_i,
    input  logic                 fp_mul_i,
    input  logic [REG_WIDTH-1:0] rdE_i,
    input  logic                 stop_i,
    input  logic                 flush_i,
    output logic                 fp_start_o,
    output logic                 fp_op_o,
    output logic                 fp_abort_o,
    output logic                 fp_result_valid_o,
    output logic                 fp_busy_o,
    output logic [REG_WIDTH-1:0] fp_rd_o,
    output logic                 stall_PC_o,
    output logic                 stall_IF_ID_o,
    output logic                 stall_ID_EX_o,
    output logic                 bubble_EX_MEM_o,
    output logic                 halted_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_WB,
        S_DRAIN,
        S_HALT
    } state_t;

    // BUSY counter preload: the start cycle and the WB cycle are not counted
    // by the BUSY countdown, so BUSY lasts LAT-2 cycles (cnt runs LAT-3..0).
    localparam logic [CNT_W-1:0] ADDF_CNT  = CNT_W'(ADDF_LAT - 3);
    localparam logic [CNT_W-1:0] MULTF_CNT = CNT_W'(MULTF_LAT - 3);
    localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 op_nxt;
    logic [REG_WIDTH-1:0] rd_nxt;
    logic                 start_short;

    // A two-cycle op skips BUSY entirely and goes straight to WB.
    assign start_short = fp_mul_i ? (MULTF_LAT == 2) : (ADDF_LAT == 2);

    // Next-state, counter and output decode from state and inputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_nxt         = state;
        cnt_nxt           = cnt;
        op_nxt            = fp_op_o;
        rd_nxt            = fp_rd_o;
        fp_start_o        = 1'b0;
        fp_abort_o        = 1'b0;
        fp_result_valid_o = 1'b0;
        fp_busy_o         = 1'b0;
        stall_PC_o        = 1'b0;
        stall_IF_ID_o     = 1'b0;
        stall_ID_EX_o     = 1'b0;
        bubble_EX_MEM_o   = 1'b0;
        halted_o          = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (FloatingE_i && !flush_i) begin
                    // FP start wins over stop_i; ID is held, so STOP comes back later.
                    fp_start_o      = 1'b1;
                    stall_PC_o      = 1'b1;
                    stall_IF_ID_o   = 1'b1;
                    stall_ID_EX_o   = 1'b1;
                    bubble_EX_MEM_o = 1'b1;
                    op_nxt          = fp_mul_i;
                    rd_nxt          = rdE_i;
                    if (start_short) begin
                        state_nxt = S_WB;
                    end else begin
                        state_nxt = S_BUSY;
                        cnt_nxt   = fp_mul_i ? MULTF_CNT : ADDF_CNT;
                    end
                end else if (FloatingE_i) begin
                    // Flushed FP instruction: it never starts.
                    state_nxt = S_IDLE;
                end else if (stop_i) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = DRAIN_CNT;
                end
            end
            S_BUSY: begin
                stall_PC_o      = 1'b1;
                stall_IF_ID_o   = 1'b1;
                stall_ID_EX_o   = 1'b1;
                bubble_EX_MEM_o = 1'b1;
                fp_busy_o       = 1'b1;
                if (flush_i) begin
                    fp_abort_o = 1'b1;
                    state_nxt  = S_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = S_WB;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_WB: begin
                fp_busy_o         = 1'b1;
                fp_result_valid_o = !flush_i;
                fp_abort_o        = flush_i;
                state_nxt         = S_IDLE;
            end
            S_DRAIN: begin
                // Front end frozen while older instructions leave the pipe.
                stall_PC_o    = 1'b1;
                stall_IF_ID_o = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_HALT;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_HALT: begin
                stall_PC_o    = 1'b1;
                stall_IF_ID_o = 1'b1;
                stall_ID_EX_o = 1'b1;
                halted_o      = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and latched op/destination registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            fp_op_o <= 1'b0;
            fp_rd_o <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            fp_op_o <= op_nxt;
            fp_rd_o <= rd_nxt;
        end
    end

endmodule
